// File: rtl/qlearn_pkg.sv
// Shared types and defaults for the Q-learning episode sequencer and its grid helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qlearn_pkg;

    localparam int DEF_STATE_W    = 16;
    localparam int DEF_ACT_W      = 3;
    localparam int DEF_PIPE_DEPTH = 6;

    // Fibonacci taps 16, 14, 13, 11 expressed as bit positions 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Compass moves; y grows downward, x grows to the right.
    typedef enum logic [DEF_ACT_W-1:0] {
        ACT_L  = 3'd0,
        ACT_LU = 3'd1,
        ACT_U  = 3'd2,
        ACT_UR = 3'd3,
        ACT_R  = 3'd4,
        ACT_RD = 3'd5,
        ACT_D  = 3'd6,
        ACT_DL = 3'd7
    } action_e;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } grid_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fsm_state_e;

    // One left shift of the action LFSR with XOR feedback into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/qlearn_grid_step.sv
// Grid transition (s, a) -> nexts; a move that leaves the 256x256 grid keeps s unchanged.
// Latency: combinational.
// Backpressure: none.
module qlearn_grid_step
    import qlearn_pkg::*;
(
    input  logic [DEF_STATE_W-1:0] s,
    input  logic [DEF_ACT_W-1:0]   a,
    output logic [DEF_STATE_W-1:0] nexts
);

    grid_state_t cur;
    logic        dec_x, inc_x, dec_y, inc_y;
    logic        wall;
    logic [7:0]  nx, ny;

    assign cur = grid_state_t'(s);

    // Decode the compass move into per-axis increment/decrement flags.
    always_comb begin
        dec_x = 1'b0;
        inc_x = 1'b0;
        dec_y = 1'b0;
        inc_y = 1'b0;
        case (a)
            ACT_L:  dec_x = 1'b1;
            ACT_LU: begin dec_x = 1'b1; dec_y = 1'b1; end
            ACT_U:  dec_y = 1'b1;
            ACT_UR: begin inc_x = 1'b1; dec_y = 1'b1; end
            ACT_R:  inc_x = 1'b1;
            ACT_RD: begin inc_x = 1'b1; inc_y = 1'b1; end
            ACT_D:  inc_y = 1'b1;
            ACT_DL: begin dec_x = 1'b1; inc_y = 1'b1; end
            default: ;
        endcase
    end

    // Any axis hitting an edge cancels the whole move, including the other axis.
    assign wall = (dec_x && (cur.x == 8'h00)) || (inc_x && (cur.x == 8'hFF)) ||
                  (dec_y && (cur.y == 8'h00)) || (inc_y && (cur.y == 8'hFF));

    assign nx = cur.x + {7'd0, inc_x} - {7'd0, dec_x};
    assign ny = cur.y + {7'd0, inc_y} - {7'd0, dec_y};

    assign nexts = wall ? s : {nx, ny};

endmodule

// File: rtl/qlearn_episode_ctrl.sv
// Episode sequencer: walks the grid with LFSR actions, issuing one (s, a) per cycle into the Q-update pipe.
// Latency: first issue two cycles after an accepted start; issue outputs are registered.
// Backpressure: with QL_HAZARD_STALL_EN a bubble is inserted while s or nexts matches an in-flight write-back.
module qlearn_episode_ctrl
    import qlearn_pkg::*;
#(
    parameter int          STATE_W    = DEF_STATE_W,
    parameter int          ACT_W      = DEF_ACT_W,
    parameter int          PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] start_state,
    input  logic [STATE_W-1:0] goal_state,
    input  logic [15:0]        max_steps,
    input  logic [15:0]        num_episodes,
    output logic               issue_valid,
    output logic [STATE_W-1:0] issue_state,
    output logic [ACT_W-1:0]   issue_action,
    output logic               busy,
    output logic               done,
    output logic [15:0]        episode_idx,
    output logic [15:0]        step_cnt,
    output logic [31:0]        stall_cnt
);

    fsm_state_e         fsm;
    logic [STATE_W-1:0] cur_s;
    logic [STATE_W-1:0] nexts;
    logic [STATE_W-1:0] start_cfg;
    logic [STATE_W-1:0] goal_cfg;
    logic [15:0]        max_cfg;
    logic [15:0]        neps_cfg;
    logic [15:0]        lfsr;
    logic [16:0]        step_lim;
    logic               hazard;
    logic               drain_done;
    logic               issue_now;
    logic               last_step;
    logic               last_ep;

    qlearn_grid_step u_grid_step (
        .s     (cur_s),
        .a     (lfsr[ACT_W-1:0]),
        .nexts (nexts)
    );

    // A zero step limit means the full 65536-step episode.
    assign step_lim  = (max_cfg == 16'd0) ? 17'h10000 : {1'b0, max_cfg};
    assign last_step = (({1'b0, step_cnt} + 17'd1) == step_lim);
    assign last_ep   = (episode_idx == (neps_cfg - 16'd1));
    assign issue_now = (fsm == ST_RUN) && !hazard;

`ifdef QL_HAZARD_STALL_EN
    logic [PIPE_DEPTH-1:0] sb_vld;
    logic [STATE_W-1:0]    sb_st [PIPE_DEPTH];

    // In-flight write-back tracker; entry i retires PIPE_DEPTH cycles after it was issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_vld <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) sb_st[i] <= '0;
        end else begin
            sb_vld   <= {sb_vld[PIPE_DEPTH-2:0], issue_now};
            sb_st[0] <= cur_s;
            for (int i = 1; i < PIPE_DEPTH; i++) sb_st[i] <= sb_st[i-1];
        end
    end

    // Stall when the Q read of s or the Qmax read of nexts would race a pending write.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_vld[i] && ((sb_st[i] == cur_s) || (sb_st[i] == nexts))) hazard = 1'b1;
        end
    end

    assign drain_done = ~|sb_vld;
`else
    localparam int DCW = $clog2(PIPE_DEPTH + 1);
    logic [DCW-1:0] drain_cnt;

    assign hazard = 1'b0;

    // Without the tracker, drain simply waits out the pipeline depth.
    always_ff @(posedge clk) begin
        if (rst || (fsm != ST_DRAIN)) drain_cnt <= '0;
        else                          drain_cnt <= drain_cnt + DCW'(1);
    end

    assign drain_done = (drain_cnt == DCW'(PIPE_DEPTH));
`endif

    // Episode FSM with registered issue, status and counter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm          <= ST_IDLE;
            cur_s        <= '0;
            start_cfg    <= '0;
            goal_cfg     <= '0;
            max_cfg      <= '0;
            neps_cfg     <= '0;
            lfsr         <= LFSR_SEED;
            issue_valid  <= 1'b0;
            issue_state  <= '0;
            issue_action <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            episode_idx  <= '0;
            step_cnt     <= '0;
            stall_cnt    <= '0;
        end else begin
            issue_valid <= 1'b0;
            case (fsm)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        start_cfg   <= start_state;
                        goal_cfg    <= goal_state;
                        max_cfg     <= max_steps;
                        neps_cfg    <= num_episodes;
                        cur_s       <= start_state;
                        episode_idx <= '0;
                        step_cnt    <= '0;
                        stall_cnt   <= '0;
                        if (num_episodes == 16'd0) begin
                            fsm  <= ST_DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            fsm  <= ST_RUN;
                            busy <= 1'b1;
                            done <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (hazard) begin
                        if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
                    end else begin
                        issue_valid  <= 1'b1;
                        issue_state  <= cur_s;
                        issue_action <= lfsr[ACT_W-1:0];
                        lfsr         <= lfsr_next(lfsr);
                        cur_s        <= nexts;
                        step_cnt     <= step_cnt + 16'd1;
                        if ((nexts == goal_cfg) || last_step) fsm <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        if (last_ep) begin
                            fsm  <= ST_DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            fsm         <= ST_RUN;
                            episode_idx <= episode_idx + 16'd1;
                            step_cnt    <= '0;
                            cur_s       <= start_cfg;
                        end
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule
